// File: rtl/conv1d_cmd_sequencer.sv
// Hardware job engine for the conv1d CFU command port: programs parameters, streams input and
// kernel bytes from memory, fires computation and returns every output word on a stream.
module conv1d_cmd_sequencer #(
    parameter int unsigned CNT_W   = 18,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [6:0]  NOP_CMD = 7'd127
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] k_base,
    input  logic [CNT_W-1:0]  in_len,
    input  logic [CNT_W-1:0]  k_len,
    input  logic [10:0]       out_len,
    input  logic [31:0]       cfg_input_offset,
    input  logic [31:0]       cfg_width,
    input  logic [31:0]       cfg_depth,
    input  logic [31:0]       cfg_bias,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [7:0]        mem_rsp_data,
    output logic [6:0]        cmd,
    output logic [31:0]       inp0,
    output logic [31:0]       inp1,
    input  logic [31:0]       ret,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last
);

    typedef enum logic [3:0] {
        StIdle, StParam, StReq, StWait, StWr, StClear, StCompute, StCompNop,
        StIssue, StCapture, StPresent, StGap, StDone
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e             state_q, state_d;
    logic [1:0]         pidx_q, pidx_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               kern_q, kern_d;
    logic [7:0]         byte_q, byte_d;
    logic [ADDR_W-1:0]  in_base_q, in_base_d, k_base_q, k_base_d;
    logic [CNT_W-1:0]   in_len_q, in_len_d, k_len_q, k_len_d;
    logic [10:0]        out_len_q, out_len_d;
    logic [31:0]        cfg_off_q, cfg_off_d, cfg_w_q, cfg_w_d;
    logic [31:0]        cfg_dp_q, cfg_dp_d, cfg_b_q, cfg_b_d;

    logic               busy_d, done_d, req_valid_d, out_valid_d, out_last_d;
    logic [ADDR_W-1:0]  req_addr_d;
    logic [6:0]         cmd_d;
    logic [31:0]        inp0_d, inp1_d, out_data_d;

    logic [CNT_W-1:0]   idx_inc, idx_d_inc, cur_len, out_len_ext;

    assign idx_inc     = idx_q + CntOne;
    assign idx_d_inc   = idx_d + CntOne;
    assign cur_len     = kern_q ? k_len_q : in_len_q;
    assign out_len_ext = CNT_W'(out_len_q);

    always_comb begin
        state_d   = state_q;
        pidx_d    = pidx_q;
        idx_d     = idx_q;
        kern_d    = kern_q;
        byte_d    = byte_q;
        in_base_d = in_base_q;
        k_base_d  = k_base_q;
        in_len_d  = in_len_q;
        k_len_d   = k_len_q;
        out_len_d = out_len_q;
        cfg_off_d = cfg_off_q;
        cfg_w_d   = cfg_w_q;
        cfg_dp_d  = cfg_dp_q;
        cfg_b_d   = cfg_b_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    in_base_d = in_base;
                    k_base_d  = k_base;
                    in_len_d  = in_len;
                    k_len_d   = k_len;
                    out_len_d = out_len;
                    cfg_off_d = cfg_input_offset;
                    cfg_w_d   = cfg_width;
                    cfg_dp_d  = cfg_depth;
                    cfg_b_d   = cfg_bias;
                    pidx_d    = 2'd0;
                    state_d   = StParam;
                end
            end
            StParam: begin
                pidx_d = pidx_q + 2'd1;
                if (pidx_q == 2'd3) begin
                    idx_d = '0;
                    if (in_len_q != '0) begin
                        kern_d  = 1'b0;
                        state_d = StReq;
                    end else if (k_len_q != '0) begin
                        kern_d  = 1'b1;
                        state_d = StReq;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (mem_rsp_valid) begin
                    byte_d  = mem_rsp_data;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (idx_inc != cur_len) begin
                    idx_d   = idx_inc;
                    state_d = StReq;
                end else if (!kern_q && k_len_q != '0) begin
                    idx_d   = '0;
                    kern_d  = 1'b1;
                    state_d = StReq;
                end else begin
                    state_d = StClear;
                end
            end
            StClear:   state_d = StCompute;
            StCompute: state_d = StCompNop;
            StCompNop: begin
                idx_d   = '0;
                state_d = (out_len_q == '0) ? StDone : StIssue;
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StPresent;
            StPresent: begin
                if (out_ready) begin
                    if (idx_inc == out_len_ext) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = StGap;
                    end
                end
            end
            StGap:   state_d = StIssue;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        cmd_d       = NOP_CMD;
        inp0_d      = '0;
        inp1_d      = '0;
        req_valid_d = 1'b0;
        req_addr_d  = '0;
        out_data_d  = (state_q == StCapture) ? ret : out_data;
        busy_d      = (state_d != StIdle) && (state_d != StDone);
        done_d      = (state_d == StDone);
        out_valid_d = (state_d == StPresent);
        out_last_d  = (state_d == StPresent) && (idx_d_inc == out_len_ext);
        unique case (state_d)
            StParam: begin
                unique case (pidx_d)
                    2'd0: begin cmd_d = 7'd20; inp1_d = cfg_off_d; end
                    2'd1: begin cmd_d = 7'd25; inp1_d = cfg_w_d;   end
                    2'd2: begin cmd_d = 7'd26; inp1_d = cfg_dp_d;  end
                    2'd3: begin cmd_d = 7'd27; inp1_d = cfg_b_d;   end
                endcase
            end
            StReq: begin
                req_valid_d = 1'b1;
                req_addr_d  = (kern_d ? k_base_d : in_base_d) + ADDR_W'(idx_d);
            end
            StWr: begin
                cmd_d  = kern_d ? 7'd11 : 7'd10;
                inp0_d = 32'(idx_d);
                inp1_d = {{24{byte_d[7]}}, byte_d};
            end
            StClear:   cmd_d = 7'd15;
            StCompute: cmd_d = 7'd40;
            StIssue: begin
                cmd_d  = 7'd12;
                inp0_d = 32'(idx_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pidx_q        <= '0;
            idx_q         <= '0;
            kern_q        <= 1'b0;
            byte_q        <= '0;
            in_base_q     <= '0;
            k_base_q      <= '0;
            in_len_q      <= '0;
            k_len_q       <= '0;
            out_len_q     <= '0;
            cfg_off_q     <= '0;
            cfg_w_q       <= '0;
            cfg_dp_q      <= '0;
            cfg_b_q       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            cmd           <= NOP_CMD;
            inp0          <= '0;
            inp1          <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pidx_q        <= pidx_d;
            idx_q         <= idx_d;
            kern_q        <= kern_d;
            byte_q        <= byte_d;
            in_base_q     <= in_base_d;
            k_base_q      <= k_base_d;
            in_len_q      <= in_len_d;
            k_len_q       <= k_len_d;
            out_len_q     <= out_len_d;
            cfg_off_q     <= cfg_off_d;
            cfg_w_q       <= cfg_w_d;
            cfg_dp_q      <= cfg_dp_d;
            cfg_b_q       <= cfg_b_d;
            busy          <= busy_d;
            done          <= done_d;
            mem_req_valid <= req_valid_d;
            mem_req_addr  <= req_addr_d;
            cmd           <= cmd_d;
            inp0          <= inp0_d;
            inp1          <= inp1_d;
            out_valid     <= out_valid_d;
            out_data      <= out_data_d;
            out_last      <= out_last_d;
        end
    end

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Bench for conv1d_cmd_sequencer: memory and conv1d models, event monitor, and per-scenario
// tasks comparing the observed command/request/output trace to a trace built from job rules.
module tb_conv1d_cmd_sequencer;

    localparam logic [6:0] NOP = 7'd127;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [31:0] in_base = '0, k_base = '0;
    logic [17:0] in_len = '0, k_len = '0;
    logic [10:0] out_len = '0;
    logic [31:0] cfg_io = '0, cfg_w = '0, cfg_d = '0, cfg_b = '0;
    logic        busy, done, mem_req_valid, out_valid, out_last;
    logic [31:0] mem_req_addr, inp0, inp1, out_data;
    logic        mem_rsp_valid = 1'b0, rsp_real = 1'b0;
    logic [7:0]  mem_rsp_data = '0;
    logic [6:0]  cmd;
    logic [31:0] ret = '0;
    logic        out_ready = 1'b0;

    conv1d_cmd_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .in_base(in_base), .k_base(k_base),
        .in_len(in_len), .k_len(k_len), .out_len(out_len), .cfg_input_offset(cfg_io),
        .cfg_width(cfg_w), .cfg_depth(cfg_d), .cfg_bias(cfg_b), .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .cmd(cmd), .inp0(inp0),
        .inp1(inp1), .ret(ret), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [6:0] c; logic [31:0] a; logic [31:0] v; } ev_t;

    int          n_checks = 0, n_pass = 0, cyc = 0, done_cnt = 0, ov_cnt = 0;
    int          lat = 1;
    bit          spur_en = 1'b0;
    ev_t         cmd_q[$];
    logic [31:0] req_q[$], od_q[$];
    logic        ol_q[$];
    int          req_cyc[$], rsp_cyc[$];
    logic [7:0]  mem_ov [int unsigned];
    logic [31:0] retmem [0:1023];
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5a;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // conv1d model: ret is registered from the address presented with cmd 12
    always @(posedge clk) if (cmd == 7'd12) ret <= retmem[inp0[9:0]];

    // Byte memory: fixed latency per request, optional stray strobes while nothing is pending
    always @(posedge clk) begin
        mem_rsp_valid <= 1'b0;
        rsp_real      <= 1'b0;
        mem_rsp_data  <= 8'($urandom);
        if (reset) begin
            pend <= 1'b0;
        end else if (mem_req_valid) begin
            if (lat <= 1) begin
                mem_rsp_valid <= 1'b1; rsp_real <= 1'b1;
                mem_rsp_data  <= get_byte(mem_req_addr);
            end else begin
                pend <= 1'b1; cnt <= lat - 1; paddr <= mem_req_addr;
            end
        end else if (pend) begin
            if (cnt == 1) begin
                pend <= 1'b0; mem_rsp_valid <= 1'b1; rsp_real <= 1'b1;
                mem_rsp_data <= get_byte(paddr);
            end else begin
                cnt <= cnt - 1;
            end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mem_rsp_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmd !== NOP) cmd_q.push_back('{cyc: cyc, c: cmd, a: inp0, v: inp1});
        if (mem_req_valid === 1'b1) begin req_q.push_back(mem_req_addr); req_cyc.push_back(cyc); end
        if (mem_rsp_valid === 1'b1 && rsp_real) rsp_cyc.push_back(cyc);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            od_q.push_back(out_data); ol_q.push_back(out_last);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
    end

    int jb_c, jb_r, jb_rs, jb_o;

    task automatic test_job(input string name, input logic [31:0] ib, input logic [31:0] kb,
                            input int il, input int kl, input int ol, input int lt,
                            input bit rnd);
        logic [31:0] co = $urandom, cw = $urandom, cd = $urandom, cb = $urandom;
        logic [6:0]  xc[$];
        logic [31:0] xa[$], xv[$];
        bit [1:0]    xm[$];
        int          bd, done_cyc = 0, nx, base_k, c40, nxt;
        bit          seen = 1'b0;
        ev_t         e;
        lat = lt; spur_en = rnd;
        in_base = ib; k_base = kb; in_len = 18'(il); k_len = 18'(kl); out_len = 11'(ol);
        cfg_io = co; cfg_w = cw; cfg_d = cd; cfg_b = cb;
        jb_c = cmd_q.size(); jb_r = req_q.size(); jb_rs = rsp_cyc.size(); jb_o = od_q.size();
        bd = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        else n_pass++;
        // job inputs must have been latched; scramble them
        in_base = $urandom; k_base = $urandom; in_len = 18'($urandom); k_len = 18'($urandom);
        out_len = 11'($urandom); cfg_io = $urandom; cfg_b = $urandom;
        for (int c = 0; c < 5000 && !seen; c++) begin
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            start     = rnd && ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
            if (done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            $display("FAIL %s done_timeout: got no done want done", name);
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        end else begin
            n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        else n_pass++;
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done_cnt - bd != 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - bd);
        else n_pass++;

        xc = '{7'd20, 7'd25, 7'd26, 7'd27};
        xa = '{32'd0, 32'd0, 32'd0, 32'd0};
        xv = '{co, cw, cd, cb};
        xm = '{2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < il; i++) begin
            xc.push_back(7'd10); xa.push_back(32'(i)); xm.push_back(2'd3);
            xv.push_back(32'($signed(get_byte(ib + 32'(i)))));
        end
        for (int i = 0; i < kl; i++) begin
            xc.push_back(7'd11); xa.push_back(32'(i)); xm.push_back(2'd3);
            xv.push_back(32'($signed(get_byte(kb + 32'(i)))));
        end
        xc.push_back(7'd15); xa.push_back(0); xv.push_back(0); xm.push_back(2'd0);
        xc.push_back(7'd40); xa.push_back(0); xv.push_back(0); xm.push_back(2'd0);
        for (int j = 0; j < ol; j++) begin
            xc.push_back(7'd12); xa.push_back(32'(j)); xv.push_back(0); xm.push_back(2'd1);
        end

        nx = cmd_q.size() - jb_c;
        n_checks++;
        if (nx != xc.size()) $display("FAIL %s cmd_count: got %0d want %0d", name, nx, xc.size());
        else n_pass++;
        if (nx == xc.size()) begin
            for (int k = 0; k < nx; k++) begin
                e = cmd_q[jb_c + k];
                n_checks++;
                if (e.c !== xc[k]) $display("FAIL %s cmd[%0d]: got %0d want %0d", name, k, e.c, xc[k]);
                else n_pass++;
                if (xm[k][0]) begin
                    n_checks++;
                    if (e.a !== xa[k]) $display("FAIL %s inp0[%0d]: got %h want %h", name, k, e.a, xa[k]);
                    else n_pass++;
                end
                if (xm[k][1]) begin
                    n_checks++;
                    if (e.v !== xv[k]) $display("FAIL %s inp1[%0d]: got %h want %h", name, k, e.v, xv[k]);
                    else n_pass++;
                end
            end
            n_checks++;
            if (cmd_q[jb_c + 3].cyc - cmd_q[jb_c].cyc != 3)
                $display("FAIL %s param_span: got %0d want 3", name,
                         cmd_q[jb_c + 3].cyc - cmd_q[jb_c].cyc);
            else n_pass++;
            c40 = cmd_q[jb_c + 5 + il + kl].cyc;
            nxt = (ol == 0) ? done_cyc : cmd_q[jb_c + 6 + il + kl].cyc;
            n_checks++;
            if (nxt != c40 + 2) $display("FAIL %s after_compute: got %0d want %0d", name, nxt, c40 + 2);
            else n_pass++;
        end

        n_checks++;
        if (req_q.size() - jb_r != il + kl)
            $display("FAIL %s req_count: got %0d want %0d", name, req_q.size() - jb_r, il + kl);
        else n_pass++;
        if (req_q.size() - jb_r == il + kl) begin
            for (int k = 0; k < il + kl; k++) begin
                base_k = k;
                n_checks++;
                if (k < il) begin
                    if (req_q[jb_r + k] !== ib + 32'(k))
                        $display("FAIL %s req_addr[%0d]: got %h want %h", name, k, req_q[jb_r + k], ib + 32'(k));
                    else n_pass++;
                end else begin
                    base_k = k - il;
                    if (req_q[jb_r + k] !== kb + 32'(base_k))
                        $display("FAIL %s req_addr[%0d]: got %h want %h", name, k, req_q[jb_r + k], kb + 32'(base_k));
                    else n_pass++;
                end
            end
        end

        n_checks++;
        if (od_q.size() - jb_o != ol) $display("FAIL %s out_count: got %0d want %0d", name, od_q.size() - jb_o, ol);
        else n_pass++;
        if (od_q.size() - jb_o == ol) begin
            for (int j = 0; j < ol; j++) begin
                n_checks++;
                if (od_q[jb_o + j] !== retmem[j])
                    $display("FAIL %s out_data[%0d]: got %h want %h", name, j, od_q[jb_o + j], retmem[j]);
                else n_pass++;
                n_checks++;
                if (ol_q[jb_o + j] !== (j == ol - 1))
                    $display("FAIL %s out_last[%0d]: got %b want %b", name, j, ol_q[jb_o + j], j == ol - 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got[10];
        logic [31:0] want[10];
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got  = '{32'(cmd), inp0, inp1, 32'(busy), 32'(done), 32'(mem_req_valid), mem_req_addr,
                 32'(out_valid), 32'(out_last), out_data};
        want = '{32'(NOP), 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got[i] !== want[i]) $display("FAIL reset_out[%0d]: got %h want %h", i, got[i], want[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        mem_ov[32'h100] = 8'h01; mem_ov[32'h101] = 8'h02;
        mem_ov[32'h102] = 8'hff; mem_ov[32'h103] = 8'h03;
        test_job("basic", 32'h100, 32'h200, 4, 2, 3, 1, 1'b0);
        n_checks++;
        if (cmd_q[jb_c + 5].cyc - cmd_q[jb_c + 4].cyc != 3)
            $display("FAIL basic byte_period: got %0d want 3", cmd_q[jb_c + 5].cyc - cmd_q[jb_c + 4].cyc);
        else n_pass++;
        n_checks++;
        if (cmd_q[jb_c + 6].v !== 32'hffffffff)
            $display("FAIL basic sext: got %h want ffffffff", cmd_q[jb_c + 6].v);
        else n_pass++;
    endtask

    task automatic test_ret_addr5();
        retmem[5] = 32'h12345678;
        test_job("ret5", 32'h40, 32'h80, 1, 1, 6, 1, 1'b0);
        n_checks++;
        if (od_q[jb_o + 5] !== 32'h12345678)
            $display("FAIL ret5 word6: got %h want 12345678", od_q[jb_o + 5]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic        l0;
        int          bad = 0, n12 = 0, bd, bo;
        bit          ok;
        lat = 1; spur_en = 1'b0;
        in_len = '0; k_len = '0; out_len = 11'd2; out_ready = 1'b0;
        bd = done_cnt; bo = od_q.size();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin @(posedge clk); #1; ok = (out_valid === 1'b1); end
        n_checks++;
        if (!ok) $display("FAIL bp first_valid: got 0 want 1"); else n_pass++;
        d0 = out_data; l0 = out_last;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0) bad++;
            if (cmd === 7'd12) n12++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp stable: got %0d unstable cycles want 0", bad); else n_pass++;
        n_checks++;
        if (n12 != 0) $display("FAIL bp no_issue: got %0d cmd12 want 0", n12); else n_pass++;
        n_checks++;
        if (d0 !== retmem[0] || l0 !== 1'b0)
            $display("FAIL bp word0: got %h/%b want %h/0", d0, l0, retmem[0]);
        else n_pass++;
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp valid_drop: got %b want 0", out_valid); else n_pass++;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin @(posedge clk); #1; ok = (out_valid === 1'b1); end
        n_checks++;
        if (!ok || out_last !== 1'b1 || out_data !== retmem[1])
            $display("FAIL bp word1: got %b/%h want 1/%h", out_last, out_data, retmem[1]);
        else n_pass++;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin @(posedge clk); #1; ok = (done === 1'b1); end
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done_cnt - bd != 1 || od_q.size() - bo != 2)
            $display("FAIL bp finish: got %0d done %0d words want 1 done 2 words", done_cnt - bd, od_q.size() - bo);
        else n_pass++;
    endtask

    task automatic test_latency7();
        test_job("lat7", 32'h300, 32'h0, 2, 0, 0, 7, 1'b0);
        n_checks++;
        if (rsp_cyc.size() - jb_rs != 2)
            $display("FAIL lat7 rsp_count: got %0d want 2", rsp_cyc.size() - jb_rs);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cmd_q[jb_c + 4 + i].cyc != rsp_cyc[jb_rs + i] + 1)
                $display("FAIL lat7 wr_after_rsp[%0d]: got %0d want %0d", i, cmd_q[jb_c + 4 + i].cyc,
                         rsp_cyc[jb_rs + i] + 1);
            else n_pass++;
            n_checks++;
            if (rsp_cyc[jb_rs + i] - req_cyc[jb_r + i] != 7)
                $display("FAIL lat7 latency[%0d]: got %0d want 7", i, rsp_cyc[jb_rs + i] - req_cyc[jb_r + i]);
            else n_pass++;
        end
        n_checks++;
        if (req_cyc[jb_r + 1] != cmd_q[jb_c + 4].cyc + 1)
            $display("FAIL lat7 next_req: got %0d want %0d", req_cyc[jb_r + 1], cmd_q[jb_c + 4].cyc + 1);
        else n_pass++;
    endtask

    task automatic test_zero_lengths();
        int bv = ov_cnt;
        test_job("zero", 32'h0, 32'h0, 0, 0, 0, 1, 1'b0);
        n_checks++;
        if (ov_cnt != bv) $display("FAIL zero out_valid_cycles: got %0d want 0", ov_cnt - bv);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ib, kb;
        for (int r = 0; r < 6; r++) begin
            ib = (r % 2 == 0) ? 32'hfffffff8 + 32'($urandom_range(0, 7)) : $urandom;
            kb = (r % 3 == 0) ? 32'hfffffffe : $urandom;
            test_job("rand", ib, kb, $urandom_range(0, 12), $urandom_range(0, 6),
                     $urandom_range(0, 8), $urandom_range(1, 5), 1'b1);
        end
    endtask

    task automatic test_reset_midjob();
        int  bc, bd;
        bit  ok = 1'b0;
        lat = 2; spur_en = 1'b0; out_ready = 1'b1;
        in_base = 32'h500; k_base = 32'h600; in_len = 18'd4; k_len = 18'd2; out_len = 11'd2;
        bc = cmd_q.size(); bd = done_cnt;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin @(posedge clk); #1; ok = (cmd_q.size() >= bc + 6); end
        n_checks++;
        if (!ok) $display("FAIL midreset reach_byte1: got %0d events want 6", cmd_q.size() - bc);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (cmd !== NOP || busy !== 1'b0 || mem_req_valid !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midreset outputs: got cmd=%0d busy=%b req=%b ov=%b want 127/0/0/0",
                     cmd, busy, mem_req_valid, out_valid);
        else n_pass++;
        bc = cmd_q.size();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (cmd_q.size() != bc || done_cnt != bd)
            $display("FAIL midreset quiet: got %0d cmds %0d done want 0 0", cmd_q.size() - bc, done_cnt - bd);
        else n_pass++;
        test_job("after_reset", 32'h700, 32'h800, 3, 2, 2, 1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) retmem[i] = $urandom;
        #1;
        test_reset();
        test_basic();
        test_ret_addr5();
        test_backpressure();
        test_latency7();
        test_zero_lengths();
        test_random();
        test_reset_midjob();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
